// File: rtl/pc_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pc_fetch_pkg
// Description : Shared state encoding and constants for the PC fetch sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package pc_fetch_pkg;

    typedef logic [1:0] state_t;

    localparam state_t c_IDLE   = 2'd0;
    localparam state_t c_WAIT   = 2'd1;
    localparam state_t c_SQUASH = 2'd2;

    localparam int c_PC_INC            = 4;
    localparam int c_SQUASH_CNT_WIDTH  = 16;

endpackage
`default_nettype wire

// File: rtl/pc_squash_counter.sv
`default_nettype none
// ============================================================================
// Module      : pc_squash_counter
// Description : Saturating up-counter with enable; counts dropped fetch responses.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_squash_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (en && (r_count != {WIDTH{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/pc_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_fetch_sequencer
// Description : Owns the PC, issues req/ack instruction fetches, squashes
//               wrong-path responses. Optional macro PC_FETCH_SQUASH_COUNT_EN
//               adds a saturating squash_count output.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_fetch_sequencer
    import pc_fetch_pkg::*;
#(
    parameter int                    PC_WIDTH    = 6,
    parameter int                    INSTR_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0]   RESET_PC    = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     stall,
    input  logic                     redirect_valid,
    input  logic [PC_WIDTH-1:0]      redirect_pc,
    output logic                     imem_req,
    output logic [PC_WIDTH-1:0]      imem_addr,
    input  logic                     imem_ack,
    input  logic [INSTR_WIDTH-1:0]   imem_rdata,
    output logic                     instr_valid,
    output logic [INSTR_WIDTH-1:0]   instr,
    output logic [PC_WIDTH-1:0]      instr_pc,
    output logic [PC_WIDTH-1:0]      pc_next
`ifdef PC_FETCH_SQUASH_COUNT_EN
    ,
    output logic [c_SQUASH_CNT_WIDTH-1:0] squash_count
`endif
);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [PC_WIDTH-1:0]     r_pc;
    logic [PC_WIDTH-1:0]     r_addr;
    logic [PC_WIDTH-1:0]     r_instr_pc;
    logic [INSTR_WIDTH-1:0]  r_instr;
    logic                    r_instr_valid;
    logic [PC_WIDTH-1:0]     w_redirect_pc;
    logic [PC_WIDTH-1:0]     w_pc_inc;
    logic [PC_WIDTH-1:0]     w_pc_d;
    logic                    w_deliver;
    logic                    w_drop;
    logic                    w_start;
    logic                    w_unused_lsb;

    assign w_redirect_pc = {redirect_pc[PC_WIDTH-1:2], 2'b00};
    assign w_unused_lsb  = ^redirect_pc[1:0];
    assign w_pc_inc      = r_pc + PC_WIDTH'(c_PC_INC);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                w_state_nxt = stall ? c_IDLE : c_WAIT;
            end
            c_WAIT: begin
                if (imem_ack) begin
                    w_state_nxt = stall ? c_IDLE : c_WAIT;
                end else if (redirect_valid) begin
                    w_state_nxt = c_SQUASH;
                end
            end
            c_SQUASH: begin
                if (imem_ack) begin
                    w_state_nxt = stall ? c_IDLE : c_WAIT;
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    // A new request begins on leaving IDLE or on the ack that closes the current one.
    always_comb begin
        imem_req  = (r_state != c_IDLE);
        w_deliver = (r_state == c_WAIT) && imem_ack && !redirect_valid;
        w_drop    = imem_ack && (((r_state == c_WAIT) && redirect_valid) ||
                                 (r_state == c_SQUASH));
        w_start   = (w_state_nxt == c_WAIT) && ((r_state == c_IDLE) || imem_ack);
    end

    // Redirect always beats the sequential increment.
    always_comb begin
        w_pc_d = r_pc;
        if (redirect_valid) begin
            w_pc_d = w_redirect_pc;
        end else if (w_deliver) begin
            w_pc_d = w_pc_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc          <= RESET_PC;
            r_addr        <= RESET_PC;
            r_instr       <= '0;
            r_instr_pc    <= RESET_PC;
            r_instr_valid <= 1'b0;
        end else begin
            r_pc          <= w_pc_d;
            r_instr_valid <= w_deliver;
            if (w_start) begin
                r_addr <= w_pc_d;
            end
            if (w_deliver) begin
                r_instr    <= imem_rdata;
                r_instr_pc <= r_pc;
            end
        end
    end

    assign imem_addr   = r_addr;
    assign instr_valid = r_instr_valid;
    assign instr       = r_instr;
    assign instr_pc    = r_instr_pc;
    assign pc_next     = r_instr_pc + PC_WIDTH'(c_PC_INC);

`ifdef PC_FETCH_SQUASH_COUNT_EN
    pc_squash_counter #(
        .WIDTH (c_SQUASH_CNT_WIDTH)
    ) u_squash_counter (
        .clk   (clk),
        .reset (reset),
        .en    (w_drop),
        .count (squash_count)
    );
`else
    logic w_unused_drop;
    assign w_unused_drop = w_drop;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_fetch_sequencer
// Description : Table-driven self-checking bench for pc_fetch_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_fetch_sequencer;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [5:0]  redirect_pc;
    logic        imem_req;
    logic [5:0]  imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [5:0]  instr_pc;
    logic [5:0]  pc_next;
`ifdef PC_FETCH_SQUASH_COUNT_EN
    logic [15:0] squash_count;
`endif

    int checks;
    int failures;

    pc_fetch_sequencer #(
        .PC_WIDTH    (6),
        .INSTR_WIDTH (32),
        .RESET_PC    (6'd0)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .pc_next        (pc_next)
`ifdef PC_FETCH_SQUASH_COUNT_EN
        ,
        .squash_count   (squash_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        rv;
        logic [5:0]  rpc;
        logic        ack;
        logic [31:0] rd;
        logic        req;
        logic [5:0]  addr;
        logic        vld;
        logic [5:0]  ipc;
        logic [31:0] ins;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [31:0] mk(input logic [5:0] a);
        return 32'hDEAD_0000 | {26'd0, a};
    endfunction

    task automatic add(input logic st, input logic rv, input logic [5:0] rpc,
                       input logic ack, input logic [31:0] rd, input logic req,
                       input logic [5:0] addr, input logic vld, input logic [5:0] ipc,
                       input logic [31:0] ins, input logic [15:0] cnt);
        vec_t v;
        v.stall = st; v.rv = rv; v.rpc = rpc; v.ack = ack; v.rd = rd;
        v.req = req; v.addr = addr; v.vld = vld; v.ipc = ipc; v.ins = ins; v.cnt = cnt;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic apply(input logic st, input logic rv, input logic [5:0] rpc,
                         input logic ack, input logic [31:0] rd);
        @(negedge clk);
        stall = st; redirect_valid = rv; redirect_pc = rpc; imem_ack = ack; imem_rdata = rd;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic st);
        @(negedge clk);
        reset = 1'b1; stall = st; redirect_valid = 1'b0; redirect_pc = '0;
        imem_ack = 1'b0; imem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_req", -1, {31'd0, imem_req}, 32'd0);
        chk("reset_vld", -1, {31'd0, instr_valid}, 32'd0);
        chk("reset_instr", -1, instr, 32'd0);
        chk("reset_ipc", -1, {26'd0, instr_pc}, 32'd0);
        chk("reset_addr", -1, {26'd0, imem_addr}, 32'd0);
`ifdef PC_FETCH_SQUASH_COUNT_EN
        chk("reset_cnt", -1, {16'd0, squash_count}, 32'd0);
`endif
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic [5:0] exp_next;
        checks   = 0;
        failures = 0;
        reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        imem_ack = 1'b0; imem_rdata = '0;

        //   st rv rpc    ack rd          req addr  vld ipc    ins         cnt
        add(0, 0, 6'd0,  0, 32'd0,      1, 6'd0,  0, 6'd0,  32'd0,      16'd0);
        add(0, 0, 6'd0,  1, mk(6'd0),   1, 6'd4,  1, 6'd0,  mk(6'd0),   16'd0);
        add(0, 0, 6'd0,  1, mk(6'd4),   1, 6'd8,  1, 6'd4,  mk(6'd4),   16'd0);
        add(0, 0, 6'd0,  1, mk(6'd8),   1, 6'd12, 1, 6'd8,  mk(6'd8),   16'd0);
        add(0, 0, 6'd0,  1, mk(6'd12),  1, 6'd16, 1, 6'd12, mk(6'd12),  16'd0);
        add(0, 1, 6'd40, 1, mk(6'd16),  1, 6'd40, 0, 6'd12, mk(6'd12),  16'd1);
        add(0, 0, 6'd0,  1, mk(6'd40),  1, 6'd44, 1, 6'd40, mk(6'd40),  16'd1);
        add(1, 0, 6'd0,  1, mk(6'd44),  0, 6'd44, 1, 6'd44, mk(6'd44),  16'd1);
        add(1, 0, 6'd0,  1, 32'h1234,   0, 6'd44, 0, 6'd44, mk(6'd44),  16'd1);
        add(0, 0, 6'd0,  0, 32'd0,      1, 6'd48, 0, 6'd44, mk(6'd44),  16'd1);
        add(0, 0, 6'd0,  1, mk(6'd48),  1, 6'd52, 1, 6'd48, mk(6'd48),  16'd1);
        add(0, 0, 6'd0,  1, mk(6'd52),  1, 6'd56, 1, 6'd52, mk(6'd52),  16'd1);
        add(0, 0, 6'd0,  1, mk(6'd56),  1, 6'd60, 1, 6'd56, mk(6'd56),  16'd1);
        add(0, 0, 6'd0,  1, mk(6'd60),  1, 6'd0,  1, 6'd60, mk(6'd60),  16'd1);
        add(0, 0, 6'd0,  1, mk(6'd0),   1, 6'd4,  1, 6'd0,  mk(6'd0),   16'd1);
        add(0, 0, 6'd0,  1, mk(6'd4),   1, 6'd8,  1, 6'd4,  mk(6'd4),   16'd1);
        add(0, 0, 6'd0,  0, 32'd0,      1, 6'd8,  0, 6'd4,  mk(6'd4),   16'd1);
        add(0, 1, 6'h23, 0, 32'd0,      1, 6'd8,  0, 6'd4,  mk(6'd4),   16'd1);
        add(0, 0, 6'd0,  0, 32'd0,      1, 6'd8,  0, 6'd4,  mk(6'd4),   16'd1);
        add(0, 0, 6'd0,  1, mk(6'd8),   1, 6'h20, 0, 6'd4,  mk(6'd4),   16'd2);
        add(0, 0, 6'd0,  1, mk(6'h20),  1, 6'h24, 1, 6'h20, mk(6'h20),  16'd2);
        add(0, 1, 6'h11, 0, 32'd0,      1, 6'h24, 0, 6'h20, mk(6'h20),  16'd2);
        add(0, 1, 6'h30, 1, mk(6'h24),  1, 6'h30, 0, 6'h20, mk(6'h20),  16'd3);
        add(0, 0, 6'd0,  1, mk(6'h30),  1, 6'h34, 1, 6'h30, mk(6'h30),  16'd3);

        do_reset(1'b0);
        foreach (vecs[i]) begin
            apply(vecs[i].stall, vecs[i].rv, vecs[i].rpc, vecs[i].ack, vecs[i].rd);
            exp_next = vecs[i].ipc + 6'd4;
            chk("imem_req", i, {31'd0, imem_req}, {31'd0, vecs[i].req});
            chk("imem_addr", i, {26'd0, imem_addr}, {26'd0, vecs[i].addr});
            chk("instr_valid", i, {31'd0, instr_valid}, {31'd0, vecs[i].vld});
            chk("instr_pc", i, {26'd0, instr_pc}, {26'd0, vecs[i].ipc});
            chk("instr", i, instr, vecs[i].ins);
            chk("pc_next", i, {26'd0, pc_next}, {26'd0, exp_next});
`ifdef PC_FETCH_SQUASH_COUNT_EN
            chk("squash_count", i, {16'd0, squash_count}, {16'd0, vecs[i].cnt});
`endif
        end

        // Stall held from reset: no request until stall drops.
        do_reset(1'b1);
        for (int k = 0; k < 5; k++) begin
            apply(1'b1, 1'b0, 6'd0, 1'b0, 32'd0);
            chk("stall_req_low", k, {31'd0, imem_req}, 32'd0);
        end
        apply(1'b0, 1'b0, 6'd0, 1'b0, 32'd0);
        chk("stall_release_req", 0, {31'd0, imem_req}, 32'd1);
        chk("stall_release_addr", 0, {26'd0, imem_addr}, 32'd0);

        // Reset mid-WAIT, then a late ack must be ignored.
        apply(1'b0, 1'b0, 6'd0, 1'b0, 32'd0);
        @(negedge clk);
        reset = 1'b1; imem_ack = 1'b1; imem_rdata = mk(6'd0);
        @(posedge clk);
        #1;
        chk("midreset_req", 0, {31'd0, imem_req}, 32'd0);
        chk("midreset_vld", 0, {31'd0, instr_valid}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("late_ack_vld", 0, {31'd0, instr_valid}, 32'd0);
        chk("late_ack_instr", 0, instr, 32'd0);
        chk("late_ack_req", 0, {31'd0, imem_req}, 32'd1);
        apply(1'b0, 1'b0, 6'd0, 1'b0, 32'd0);
        chk("late_ack_vld2", 0, {31'd0, instr_valid}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
